harp_sync_rx: RTL and testbench
===============================

# harp_sync_rx

Receiver end of the Harp clock-synchronisation link. It deserialises the 100 kbaud UART sync stream, parses the six-byte Harp sync frame (0xAA 0xAF + 32-bit seconds) and disciplines a local seconds/sub-second timebase to it. The timebase free-runs between frames. The block sits on the breakout input side, feeding timestamps and a once-per-second pulse to the acquisition logic.

## Interface

Parameters:
- CLK_RATE_HZ, 1000000: clk frequency; also the sub-second modulus.
- BAUD, 100000: UART bit rate. BIT_CYC = CLK_RATE_HZ/BAUD must be at least 8.
- ALIGN_CYCLES, 100: clk cycles from the stop-bit sample of the last frame byte to the second boundary it announces.
- GAP_BITS, 20: maximum idle gap between bytes inside a frame, in bit periods.

Ports:
- clk, in, 1: single clock for all logic.
- reset, in, 1: asynchronous, active-low. Asserts immediately on low; releases synchronously to clk.
- RX, in, 1: UART line, idle high, asynchronous to clk.
- seconds, out, 32: current Harp second.
- subsec, out, 32: clk cycles elapsed in the current second, range 0..CLK_RATE_HZ-1.
- sec_pulse, out, 1: one-cycle strobe at every second boundary.
- locked, out, 1: a valid frame has been applied within the last 2 seconds.
- frame_err, out, 1: one-cycle strobe on a bad stop bit or an aborted frame.
- LED, out, 1: locked AND (subsec < CLK_RATE_HZ/2).

## Operation

- **RX input**: RX passes through a 2-FF synchroniser. The bit FSM uses only the synchronised value.
- **Bit FSM** (IDLE, START, DATA, STOP):
  - IDLE → START on a falling edge.
  - START: at BIT_CYC/2 the line is rechecked. Low → DATA. High → IDLE (glitch, no error).
  - DATA: 8 bits sampled LSB first, one every BIT_CYC cycles, at bit centre.
  - STOP: samples the stop bit. High → byte_valid strobe. Low → frame_err, byte discarded. Both return to IDLE.
- **Frame FSM** (HDR0, HDR1, B0, B1, B2, B3):
  - HDR0: accept only 0xAA.
  - HDR1: 0xAF → B0. 0xAA → stay in HDR1. Any other byte → HDR0.
  - B0..B3: collect the seconds value, little-endian (B0 = bits 7:0).
  - After B3: commit the value and return to HDR0.
  - A bad stop bit in any state → HDR0.
  - In any state except HDR0, an idle gap longer than GAP_BITS*BIT_CYC cycles → HDR0 with frame_err.
- **Commit**: latch pending = value + 1 (mod 2^32) and load the align counter with ALIGN_CYCLES. A commit while the counter is already armed reloads both pending and the counter.
- **Apply**: when the armed counter reaches 0:
  - seconds ← pending, subsec ← 0, sec_pulse = 1.
  - locked ← 1, stale counter ← 0.
- **Free run**: subsec increments every cycle. At CLK_RATE_HZ-1 it wraps to 0, seconds increments (mod 2^32) and sec_pulse = 1.
- **Simultaneous apply and wrap**: the apply wins. Only one increment source acts, and one sec_pulse is produced.
- **Staleness**: the stale counter increments on each free-run wrap. When it reaches 2, locked ← 0. The timebase keeps running.
- **Reset values**: seconds = 0, subsec = 0, sec_pulse = 0, locked = 0, frame_err = 0, LED = 0. Both FSMs go to IDLE/HDR0 and the align counter is disarmed. Reset mid-byte or mid-frame discards the partial data; no strobe is emitted.

## Timing

- RX to the start-detect edge: 2-cycle synchroniser latency.
- byte_valid fires in the cycle after the stop-bit sample, i.e. 9.5*BIT_CYC + 2 ±1 cycles after the RX falling edge.
- Commit takes 1 cycle after byte_valid for B3.
- Apply lands ALIGN_CYCLES cycles after commit. seconds, subsec and sec_pulse are updated in the same cycle.
- All outputs are registered. sec_pulse and frame_err are exactly 1 cycle wide.

## Test plan

Run at CLK_RATE_HZ=1e6, BAUD=1e5, ALIGN_CYCLES=100.

- **Basic sync**: frame AA AF 10 00 00 00 → 100 cycles after the last stop sample: seconds=0x11, subsec=0, sec_pulse, locked=1. After 1e6 more cycles: seconds=0x12.
- **Header resync and bad stop**:
  - Stream AA AA AF 05 00 00 00 → seconds=6 applied.
  - Stream 55 AF 05 00 00 00 → no apply.
  - A byte whose stop bit is held low → frame_err pulse, FSM returns to HDR0.
- **Inter-byte gap**: 250 µs idle after the B1 byte → frame_err. The following valid frame FF FF FF FF (after header) applies seconds=0 (wrap).
- **Collision**: apply timed to coincide with a free-run wrap → exactly one sec_pulse, seconds = pending (no +1).
- **Lock loss**: after a sync, no frames for 2,000,000 cycles → locked=0 and LED=0 at the second wrap. seconds continues incrementing.
- **Reset mid-frame**: assert reset low during B2 → all outputs 0 immediately. After release, a full valid frame syncs normally.

Source files
------------

// File: rtl/harp_sync_rx.sv
// harp_sync_rx
// Receiver for the Harp clock-sync link. A 100 kbaud UART stream carries
// six-byte frames (0xAA 0xAF + little-endian 32-bit seconds). Each good frame
// schedules the announced second (value + 1) to be loaded ALIGN_CYCLES after
// the stop-bit sample of its last byte. Between frames the local timebase
// free-runs.
//
// Ports
//   clk        in   single clock
//   reset      in   async active-low reset, released synchronously to clk
//   RX         in   UART line, idle high, asynchronous to clk
//   seconds    out  [31:0] current Harp second
//   subsec     out  [31:0] clk cycles into the current second
//   sec_pulse  out  one-cycle strobe at each second boundary
//   locked     out  a frame was applied within the last two seconds
//   frame_err  out  one-cycle strobe on bad stop bit or aborted frame
//   LED        out  locked and in the first half of the second
module harp_sync_rx #(
  parameter int CLK_RATE_HZ  = 1000000,
  parameter int BAUD         = 100000,
  parameter int ALIGN_CYCLES = 100,
  parameter int GAP_BITS     = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RX,
  output logic [31:0] seconds,
  output logic [31:0] subsec,
  output logic        sec_pulse,
  output logic        locked,
  output logic        frame_err,
  output logic        LED
);

  localparam int BIT_CYC  = CLK_RATE_HZ / BAUD;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int GAP_CYC  = GAP_BITS * BIT_CYC;
  localparam int CW       = $clog2(BIT_CYC + 1);
  localparam int GW       = $clog2(GAP_CYC + 2);
  localparam int AW       = $clog2(ALIGN_CYCLES + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);
  localparam logic [GW-1:0] GAP_LIM   = GW'(GAP_CYC);
  localparam logic [31:0]   SUB_LAST  = 32'(CLK_RATE_HZ - 1);
  localparam logic [31:0]   SUB_HALF  = 32'(CLK_RATE_HZ / 2);

  // ---------------------------------------------------------------- reset
  // Assertion reaches every flop at once; release is retimed to clk.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // ------------------------------------------------------- RX synchroniser
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // -------------------------------------------------------------- bit FSM
  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_st_e;

  bit_st_e       bit_st_q, bit_st_d;
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic [2:0]    bidx_q, bidx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          byte_vld_q, byte_vld_d;
  logic          stop_bad_q, stop_bad_d;

  always_comb begin
    bit_st_d   = bit_st_q;
    bcnt_d     = bcnt_q + 1'b1;
    bidx_d     = bidx_q;
    shreg_d    = shreg_q;
    byte_vld_d = 1'b0;
    stop_bad_d = 1'b0;
    unique case (bit_st_q)
      B_IDLE: begin
        bcnt_d = '0;
        if (rx_prev_q && !rx_sync_q) bit_st_d = B_START;
      end
      B_START: begin
        // Mid start bit: still low means a real start, high was a glitch.
        if (bcnt_q == HALF_LAST) begin
          bcnt_d   = '0;
          bidx_d   = '0;
          bit_st_d = rx_sync_q ? B_IDLE : B_DATA;
        end
      end
      B_DATA: begin
        if (bcnt_q == BIT_LAST) begin
          bcnt_d  = '0;
          shreg_d = {rx_sync_q, shreg_q[7:1]};
          bidx_d  = bidx_q + 3'd1;
          if (bidx_q == 3'd7) bit_st_d = B_STOP;
        end
      end
      B_STOP: begin
        if (bcnt_q == BIT_LAST) begin
          bit_st_d   = B_IDLE;
          byte_vld_d = rx_sync_q;
          stop_bad_d = !rx_sync_q;
        end
      end
      default: bit_st_d = B_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_st_q   <= B_IDLE;
      bcnt_q     <= '0;
      bidx_q     <= '0;
      shreg_q    <= '0;
      byte_vld_q <= 1'b0;
      stop_bad_q <= 1'b0;
    end else begin
      bit_st_q   <= bit_st_d;
      bcnt_q     <= bcnt_d;
      bidx_q     <= bidx_d;
      shreg_q    <= shreg_d;
      byte_vld_q <= byte_vld_d;
      stop_bad_q <= stop_bad_d;
    end
  end

  // ------------------------------------------------------------ frame FSM
  // shreg_q holds the received byte while byte_vld_q is high: it only
  // shifts in DATA, and the bit FSM is back in IDLE by then.
  typedef enum logic [2:0] {F_HDR0, F_HDR1, F_B0, F_B1, F_B2, F_B3} frm_st_e;

  frm_st_e       frm_q, frm_d;
  logic [23:0]   acc_q, acc_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          commit, gap_err;

  always_comb begin
    frm_d   = frm_q;
    acc_d   = acc_q;
    commit  = 1'b0;
    gap_err = 1'b0;
    gap_d   = (frm_q == F_HDR0 || bit_st_q != B_IDLE) ? '0 : gap_q + 1'b1;
    if (stop_bad_q) begin
      frm_d = F_HDR0;
    end else if (byte_vld_q) begin
      unique case (frm_q)
        F_HDR0: if (shreg_q == 8'hAA) frm_d = F_HDR1;
        F_HDR1: begin
          // A repeated 0xAA may be the real header start; keep waiting.
          if (shreg_q == 8'hAF)      frm_d = F_B0;
          else if (shreg_q != 8'hAA) frm_d = F_HDR0;
        end
        F_B0: begin acc_d[7:0]   = shreg_q; frm_d = F_B1; end
        F_B1: begin acc_d[15:8]  = shreg_q; frm_d = F_B2; end
        F_B2: begin acc_d[23:16] = shreg_q; frm_d = F_B3; end
        F_B3: begin commit = 1'b1;          frm_d = F_HDR0; end
        default: frm_d = F_HDR0;
      endcase
    end else if (frm_q != F_HDR0 && gap_q == GAP_LIM) begin
      gap_err = 1'b1;
      frm_d   = F_HDR0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_q <= F_HDR0;
      acc_q <= '0;
      gap_q <= '0;
    end else begin
      frm_q <= frm_d;
      acc_q <= acc_d;
      gap_q <= gap_d;
    end
  end

  // ------------------------------------------------------------- timebase
  logic [31:0]   sec_q, sec_d, sub_q, sub_d, pend_q, pend_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic [1:0]    stale_q, stale_d;
  logic          armed_q, armed_d;
  logic          pulse_q, pulse_d, locked_q, locked_d, led_q, led_d, ferr_q, ferr_d;
  logic          apply, wrap;

  always_comb begin
    apply    = armed_q && (acnt_q == AW'(1));
    wrap     = (sub_q == SUB_LAST);
    pend_d   = pend_q;
    acnt_d   = acnt_q;
    armed_d  = armed_q;
    sec_d    = sec_q;
    sub_d    = sub_q + 32'd1;
    stale_d  = stale_q;
    locked_d = locked_q;
    pulse_d  = 1'b0;
    ferr_d   = stop_bad_d | gap_err;

    // A new commit re-arms even if an older one is still counting down.
    if (commit) begin
      pend_d  = {shreg_q, acc_q} + 32'd1;
      acnt_d  = AW'(ALIGN_CYCLES);
      armed_d = 1'b1;
    end else if (armed_q) begin
      acnt_d = acnt_q - 1'b1;
      if (apply) armed_d = 1'b0;
    end

    // Apply overrides a coincident wrap: one pulse, no extra increment.
    if (apply) begin
      sec_d    = pend_q;
      sub_d    = '0;
      pulse_d  = 1'b1;
      locked_d = 1'b1;
      stale_d  = '0;
    end else if (wrap) begin
      sec_d   = sec_q + 32'd1;
      sub_d   = '0;
      pulse_d = 1'b1;
      if (stale_q != 2'd2) stale_d = stale_q + 2'd1;
      if (stale_q != 2'd0) locked_d = 1'b0;
    end

    led_d = locked_d && (sub_d < SUB_HALF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= '0;
      acnt_q   <= '0;
      armed_q  <= 1'b0;
      sec_q    <= '0;
      sub_q    <= '0;
      stale_q  <= '0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
      led_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      acnt_q   <= acnt_d;
      armed_q  <= armed_d;
      sec_q    <= sec_d;
      sub_q    <= sub_d;
      stale_q  <= stale_d;
      locked_q <= locked_d;
      pulse_q  <= pulse_d;
      led_q    <= led_d;
      ferr_q   <= ferr_d;
    end
  end

  assign seconds   = sec_q;
  assign subsec    = sub_q;
  assign sec_pulse = pulse_q;
  assign locked    = locked_q;
  assign frame_err = ferr_q;
  assign LED       = led_q;

endmodule

// File: tb/tb_harp_sync_rx.sv
// Bench for harp_sync_rx at a scaled-down clock (2 kHz "second", 200 baud,
// so BIT_CYC = 10) to keep run length small. The timebase model describes
// the outputs as a function of the cycles elapsed since the latest time
// reference (reset release or frame apply).
module tb_harp_sync_rx;
  localparam int CLK_HZ    = 2000;
  localparam int BAUD      = 200;
  localparam int ALIGN     = 100;
  localparam int GAP_BITS  = 20;
  localparam int B         = CLK_HZ / BAUD;
  // Edge count from the RX falling edge to the apply edge: 2 sync stages +
  // edge detect, half a bit, 9 bits to the stop sample, commit, ALIGN.
  localparam int APPLY_LAT = 3 + B / 2 + 9 * B + 1 + ALIGN;
  localparam int BYTE_CYC  = 10 * B + 1;

  logic        clk = 1'b0, reset = 1'b0, RX = 1'b1;
  logic [31:0] seconds, subsec;
  logic        sec_pulse, locked, frame_err, LED;

  harp_sync_rx #(
    .CLK_RATE_HZ(CLK_HZ), .BAUD(BAUD), .ALIGN_CYCLES(ALIGN), .GAP_BITS(GAP_BITS)
  ) dut (
    .clk(clk), .reset(reset), .RX(RX),
    .seconds(seconds), .subsec(subsec), .sec_pulse(sec_pulse),
    .locked(locked), .frame_err(frame_err), .LED(LED)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---- model: time reference + one scheduled apply
  bit          chk_en = 0;
  int          ref_cyc = 0;
  logic [31:0] ref_sec = 0;
  bit          ref_apply = 0;
  bit          sched_v = 0;
  int          sched_at = 0;
  logic [31:0] sched_sec = 0;

  always @(negedge clk) begin : cmp
    int          d, e_sub;
    logic [31:0] e_sec;
    bit          e_pulse, e_lock, e_led;
    if (chk_en) begin
      if (sched_v && cyc == sched_at) begin
        ref_cyc = cyc; ref_sec = sched_sec; ref_apply = 1; sched_v = 0;
      end
      if (cyc >= ref_cyc) begin
        d       = cyc - ref_cyc;
        e_sub   = d % CLK_HZ;
        e_sec   = ref_sec + 32'(d / CLK_HZ);
        e_pulse = (e_sub == 0) && (d != 0 || ref_apply);
        e_lock  = ref_apply && (d < 2 * CLK_HZ);
        e_led   = e_lock && (e_sub < CLK_HZ / 2);
        chk("seconds", seconds, e_sec);
        chk("subsec", subsec, 32'(e_sub));
        chk("sec_pulse", sec_pulse, e_pulse);
        chk("locked", locked, e_lock);
        chk("LED", LED, e_led);
      end
    end
  end

  int pulse_cnt = 0, err_cnt = 0;
  bit err_prev = 0;
  always @(negedge clk) begin
    if (sec_pulse) pulse_cnt++;
    if (frame_err) begin
      err_cnt++;
      chk("frame_err_width", err_prev, 0);
    end
    err_prev = frame_err;
  end

  // ---- stimulus helpers
  int last_fall = 0;

  task automatic wait_cyc(input int n);
    while (cyc < n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop = 0);
    @(posedge clk); #1 RX = 1'b0; last_fall = cyc;
    for (int i = 0; i < 8; i++) begin
      repeat (B) @(posedge clk);
      #1 RX = b[i];
    end
    repeat (B) @(posedge clk);
    #1 RX = bad_stop ? 1'b0 : 1'b1;
    repeat (B) @(posedge clk);
    if (bad_stop) begin
      #1 RX = 1'b1;
      repeat (B) @(posedge clk);
    end
  endtask

  task automatic send_frame(input logic [31:0] v);
    send_byte(8'hAA); send_byte(8'hAF);
    for (int i = 0; i < 4; i++) send_byte(v[8*i +: 8]);
    sched_sec = v + 32'd1;
    sched_at  = last_fall + APPLY_LAT;
    sched_v   = 1;
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    ref_cyc = cyc + 2; ref_sec = 0; ref_apply = 0; sched_v = 0;
    chk_en = 1;
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_seconds"}, seconds, 0);
    chk({tag, "_subsec"}, subsec, 0);
    chk({tag, "_sec_pulse"}, sec_pulse, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_LED"}, LED, 0);
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, p0, w, k;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    release_reset();
    repeat (5) @(posedge clk);

    // Basic sync: 0x10 announced -> 0x11 applied, then one second later 0x12.
    send_frame(32'h10);
    wait_cyc(sched_at);
    chk("basic_seconds", seconds, 32'h11);
    chk("basic_subsec", subsec, 0);
    chk("basic_pulse", sec_pulse, 1);
    chk("basic_locked", locked, 1);
    chk("basic_LED", LED, 1);
    w = cyc;
    wait_cyc(w + CLK_HZ);
    chk("basic_next_second", seconds, 32'h12);

    // Header resync: AA AA AF 05 00 00 00 -> 6.
    e0 = err_cnt;
    send_byte(8'hAA);
    send_frame(32'h05);
    wait_cyc(sched_at);
    chk("resync_seconds", seconds, 32'h6);

    // 55 AF 05 00 00 00 is not a frame; the model expects no apply.
    send_byte(8'h55); send_byte(8'hAF); send_byte(8'h05);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    repeat (300) @(posedge clk);
    chk("no_err_clean_stream", err_cnt - e0, 0);

    // Bad stop bit after AA drops back to HDR0, so the following AF is junk.
    e0 = err_cnt;
    send_byte(8'hAA);
    send_byte(8'h33, 1);
    send_byte(8'hAF); send_byte(8'h07);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    repeat (300) @(posedge clk);
    chk("bad_stop_err", err_cnt - e0, 1);

    // Inter-byte gap after B1 aborts; then FF FF FF FF wraps to 0.
    e0 = err_cnt;
    send_byte(8'hAA); send_byte(8'hAF); send_byte(8'h01); send_byte(8'h02);
    repeat (250) @(posedge clk);
    chk("gap_err", err_cnt - e0, 1);
    send_frame(32'hFFFF_FFFF);
    wait_cyc(sched_at);
    chk("wrap_seconds", seconds, 32'h0);
    chk("wrap_pulse", sec_pulse, 1);
    chk("gap_err_total", err_cnt - e0, 1);

    // Collision: time the last byte so the apply lands on a free-run wrap.
    k = (cyc + 800 - ref_cyc) / CLK_HZ + 1;
    w = ref_cyc + k * CLK_HZ;
    wait_cyc(w - (APPLY_LAT + 5 * BYTE_CYC) - 1);
    send_frame(32'h1234);
    chk("collide_target", sched_at, w);
    wait_cyc(w - 3);
    p0 = pulse_cnt;
    wait_cyc(w);
    chk("collide_seconds", seconds, 32'h1235);
    chk("collide_subsec", subsec, 0);
    wait_cyc(w + 3);
    chk("collide_one_pulse", pulse_cnt - p0, 1);

    // Lock loss at the second wrap after the last apply.
    wait_cyc(w + 2 * CLK_HZ - 1);
    chk("still_locked", locked, 1);
    wait_cyc(w + 2 * CLK_HZ);
    chk("lock_lost", locked, 0);
    chk("lock_lost_LED", LED, 0);
    chk("lock_lost_seconds", seconds, 32'h1237);
    repeat (20) @(posedge clk);

    // Reset during B2: outputs clear at once, partial frame discarded.
    send_byte(8'hAA); send_byte(8'hAF); send_byte(8'h01); send_byte(8'h02);
    @(posedge clk); #1 RX = 1'b0;
    repeat (3 * B) @(posedge clk);
    #1 chk_en = 0; reset = 1'b0;
    #1 chk_zero("midreset");
    RX = 1'b1;
    e0 = err_cnt;
    repeat (5) @(posedge clk);
    release_reset();
    repeat (20 * B) @(posedge clk);
    send_frame(32'h20);
    wait_cyc(sched_at);
    chk("after_reset_seconds", seconds, 32'h21);
    chk("after_reset_locked", locked, 1);
    repeat (10) @(posedge clk);
    chk("after_reset_no_err", err_cnt - e0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
